// File: rtl/int_float_pkg.sv
// Shared types and constant helpers for the integer <-> float converter.
package int_float_pkg;

  // Default geometry; the converter itself is parametrised.
  localparam int IW_DEF = 8;
  localparam int EW_DEF = 4;
  localparam int MW_DEF = 8;

  // Float word width: {sign, exponent, fraction}.
  function automatic int float_width(input int ew, input int mw);
    return 1 + ew + mw;
  endfunction

  localparam int FW = float_width(EW_DEF, MW_DEF);

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Per-transaction conversion direction.
  localparam logic MODE_I2F = 1'b0;
  localparam logic MODE_F2I = 1'b1;

  // Bit pattern of the largest positive w-bit two's-complement value.
  function automatic logic [63:0] sat_pos_pattern(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Bit pattern of the most negative w-bit two's-complement value.
  function automatic logic [63:0] sat_neg_pattern(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/int_float_shift_unit.sv
// Working register plus exponent/count counter with a one-bit-per-cycle
// shifter. dir_i = 0 normalises (shift left until the MSB is set or the
// value is zero); dir_i = 1 denormalises (shift right until the count is 0).
module int_float_shift_unit
  import int_float_pkg::*;
#(
  parameter int IW = 8,
  parameter int EW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [IW-1:0] load_reg_i,
  input  logic [EW-1:0] load_cnt_i,
  input  logic          shift_en_i,
  input  logic          dir_i,
  output logic [IW-1:0] work_o,
  output logic [EW-1:0] cnt_o,
  output logic          done_o
);

  logic [IW-1:0] work_q;
  logic [EW-1:0] cnt_q;

  // Stop condition depends on direction: normalised/zero when shifting
  // left, count exhausted when shifting right.
  always_comb begin
    done_o = 1'b0;
    if (dir_i == MODE_I2F) begin
      done_o = (work_q == '0) || work_q[IW-1];
    end else begin
      done_o = (cnt_q == '0);
    end
  end

  // Load on accept, otherwise step one bit per cycle until done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      work_q <= load_reg_i;
      cnt_q  <= load_cnt_i;
    end else if (shift_en_i && !done_o) begin
      if (dir_i == MODE_I2F) begin
        work_q <= work_q << 1;
      end else begin
        work_q <= work_q >> 1;
      end
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign work_o = work_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/int_float_conv_seq.sv
// Sequential signed-integer <-> float converter.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready is high only in IDLE, and out_valid stays high with
// stable outputs until the edge where out_ready is also high.
module int_float_conv_seq
  import int_float_pkg::*;
#(
  parameter int IW = 8,
  parameter int EW = 4,
  parameter int MW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [IW-1:0]    in_int,
  input  logic [EW+MW:0]   in_float,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    out_int,
  output logic [EW+MW:0]   out_float,
  output logic             out_ovf,
  output logic [1:0]       dbg_state
);

  localparam int            FWL     = float_width(EW, MW);
  localparam logic [EW-1:0] IW_E    = EW'(IW);
  localparam logic [IW-1:0] SAT_POS = IW'(sat_pos_pattern(IW));
  localparam logic [IW-1:0] SAT_NEG = IW'(sat_neg_pattern(IW));

  state_t state_q, state_d;

  logic mode_q, sign_q, ovf_pre_q;

  logic           out_valid_q, out_valid_d;
  logic [IW-1:0]  out_int_q, out_int_d;
  logic [FWL-1:0] out_float_q, out_float_d;
  logic           out_ovf_q, out_ovf_d;

  // Operand decode for the load.
  logic [EW-1:0] e_in;
  logic [MW-1:0] f_in;
  logic [IW-1:0] mag_in, r_top;
  logic          f_zero, ovf_pre_in, sign_in;
  logic [IW-1:0] ld_reg;
  logic [EW-1:0] ld_cnt;
  logic          accept;

  // Shift-unit interface.
  logic          su_load, su_shift_en, su_done;
  logic [IW-1:0] work;
  logic [EW-1:0] cnt;
  logic [MW-1:0] frac;

  // Result candidates loaded into the output registers on entry to DONE.
  logic [FWL-1:0] res_float;
  logic [IW-1:0]  res_int;
  logic           res_ovf;

  assign e_in = in_float[MW +: EW];
  assign f_in = in_float[MW-1:0];

  // Top IW bits of the fraction, zero-padded when the fraction is narrower.
  if (MW > IW) begin : g_r_trunc
    assign r_top = f_in[MW-1 -: IW];
  end else if (MW == IW) begin : g_r_equal
    assign r_top = f_in;
  end else begin : g_r_pad
    assign r_top = {f_in, {(IW-MW){1'b0}}};
  end

  // Top MW bits of the normalised magnitude; extra low bits are dropped.
  if (IW > MW) begin : g_f_trunc
    assign frac = work[IW-1 -: MW];
  end else if (IW == MW) begin : g_f_equal
    assign frac = work;
  end else begin : g_f_pad
    assign frac = {work, {(MW-IW){1'b0}}};
  end

  // Working-register and counter start values for the selected mode.
  always_comb begin
    mag_in     = in_int[IW-1] ? (~in_int + 1'b1) : in_int;
    f_zero     = (e_in == '0) || (f_in == '0);
    ovf_pre_in = !f_zero && (e_in > IW_E);
    if (mode == MODE_F2I) begin
      sign_in = in_float[EW+MW];
      ld_reg  = f_zero ? '0 : r_top;
      ld_cnt  = (f_zero || ovf_pre_in) ? '0 : (IW_E - e_in);
    end else begin
      sign_in = in_int[IW-1];
      ld_reg  = mag_in;
      ld_cnt  = IW_E;
    end
  end

  assign accept      = (state_q == ST_IDLE) && in_valid;
  assign su_shift_en = (state_q == ST_SHIFT);

  int_float_shift_unit #(
    .IW (IW),
    .EW (EW)
  ) u_shift (
    .clk        (clk),
    .reset      (reset),
    .load_i     (su_load),
    .load_reg_i (ld_reg),
    .load_cnt_i (ld_cnt),
    .shift_en_i (su_shift_en),
    .dir_i      (mode_q),
    .work_o     (work),
    .cnt_o      (cnt),
    .done_o     (su_done)
  );

  // Final result: packing for int->float, overflow check, saturation and
  // negation for float->int. The unused-mode output stays zero.
  always_comb begin
    res_float = '0;
    res_int   = '0;
    res_ovf   = 1'b0;
    if (mode_q == MODE_I2F) begin
      if (work != '0) begin
        res_float = {sign_q, cnt, frac};
      end
    end else begin
      res_ovf = ovf_pre_q |
                (sign_q ? (work[IW-1] & (|work[IW-2:0])) : work[IW-1]);
      if (res_ovf) begin
        res_int = sign_q ? SAT_NEG : SAT_POS;
      end else begin
        res_int = sign_q ? (~work + 1'b1) : work;
      end
    end
  end

  // Next-state, load strobe and output-register updates.
  always_comb begin
    state_d     = state_q;
    su_load     = 1'b0;
    out_valid_d = out_valid_q;
    out_int_d   = out_int_q;
    out_float_d = out_float_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          su_load = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (su_done) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_int_d   = res_int;
          out_float_d = res_float;
          out_ovf_d   = res_ovf;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_int_q   <= '0;
      out_float_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_int_q   <= out_int_d;
      out_float_q <= out_float_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  // Per-transaction attributes captured on the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q    <= MODE_I2F;
      sign_q    <= 1'b0;
      ovf_pre_q <= 1'b0;
    end else if (accept) begin
      mode_q    <= mode;
      sign_q    <= sign_in;
      ovf_pre_q <= (mode == MODE_F2I) && ovf_pre_in;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_int   = out_int_q;
  assign out_float = out_float_q;
  assign out_ovf   = out_ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_int_float_conv_seq.sv
// Directed bench for int_float_conv_seq (IW=8, EW=4, MW=8).
module tb_int_float_conv_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [7:0]  in_int;
  logic [12:0] in_float;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_int;
  logic [12:0] out_float;
  logic        out_ovf;
  logic [1:0]  dbg_state;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  int_float_conv_seq #(.IW(8), .EW(4), .MW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .in_int    (in_int),
    .in_float  (in_float),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_int   (out_int),
    .out_float (out_float),
    .out_ovf   (out_ovf),
    .dbg_state (dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One transaction: present, accept, measure latency, check outputs,
  // optionally complete the output handshake.
  task automatic run_conv(input string tag, input logic m, input logic [7:0] ii,
                          input logic [12:0] fi, input logic [7:0] e_int,
                          input logic [12:0] e_flt, input logic e_ovf,
                          input int e_lat, input bit release_out);
    int n;
    @(negedge clk);
    chk({tag, ".in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    mode     = m;
    in_int   = ii;
    in_float = fi;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_int   = 8'($urandom_range(0, 255));
    in_float = 13'($urandom_range(0, 8191));
    mode     = 1'($urandom_range(0, 1));
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".latency"}, n, e_lat);
    chk({tag, ".out_float"}, out_float, e_flt);
    chk({tag, ".out_int"}, out_int, e_int);
    chk({tag, ".out_ovf"}, out_ovf, e_ovf);
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, ".valid_clr"}, out_valid, 0);
      chk({tag, ".ready_back"}, in_ready, 1);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    mode      = 1'b0;
    in_int    = '0;
    in_float  = '0;
    out_ready = 1'b0;

    // Reset state.
    #12;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_int", out_int, 0);
    chk("rst.out_float", out_float, 0);
    chk("rst.out_ovf", out_ovf, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.state", dbg_state, 0);
    @(negedge clk);
    reset = 1'b0;

    // Integer -> float.
    run_conv("i2f_25",   1'b0, 8'd25,  13'h0, 8'h00, 13'h05C8, 1'b0, 4, 1'b1);
    run_conv("i2f_m128", 1'b0, 8'h80,  13'h0, 8'h00, 13'h1880, 1'b0, 1, 1'b1);
    run_conv("i2f_127",  1'b0, 8'd127, 13'h0, 8'h00, 13'h07FE, 1'b0, 2, 1'b1);
    run_conv("i2f_0",    1'b0, 8'd0,   13'h0, 8'h00, 13'h0000, 1'b0, 1, 1'b1);
    run_conv("i2f_m5",   1'b0, 8'hFB,  13'h0, 8'h00, 13'h13A0, 1'b0, 6, 1'b1);

    // Float -> integer, including saturation and zero cases.
    run_conv("f2i_25",   1'b1, 8'h00, 13'h05C8, 8'd25, 13'h0, 1'b0, 4, 1'b1);
    run_conv("f2i_m5",   1'b1, 8'h00, 13'h13A0, 8'hFB, 13'h0, 1'b0, 6, 1'b1);
    run_conv("f2i_m128", 1'b1, 8'h00, 13'h1880, 8'h80, 13'h0, 1'b0, 1, 1'b1);
    run_conv("f2i_p128", 1'b1, 8'h00, 13'h0880, 8'h7F, 13'h0, 1'b1, 1, 1'b1);
    run_conv("f2i_e9",   1'b1, 8'h00, 13'h0980, 8'h7F, 13'h0, 1'b1, 1, 1'b1);
    run_conv("f2i_e10n", 1'b1, 8'h00, 13'h1AFF, 8'h80, 13'h0, 1'b1, 1, 1'b1);
    run_conv("f2i_e0",   1'b1, 8'h00, 13'h00AB, 8'h00, 13'h0, 1'b0, 1, 1'b1);

    // Backpressure: result held, new requests ignored while not drained.
    run_conv("bp_25", 1'b0, 8'd25, 13'h0, 8'h00, 13'h05C8, 1'b0, 4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      mode     = 1'b1;
      in_int   = 8'($urandom_range(0, 255));
      in_float = 13'h0880;
      chk($sformatf("bp.valid%0d", i), out_valid, 1);
      chk($sformatf("bp.float%0d", i), out_float, 13'h05C8);
      chk($sformatf("bp.in_ready%0d", i), in_ready, 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp.valid_clr", out_valid, 0);
    chk("bp.in_ready", in_ready, 1);
    chk("bp.state", dbg_state, 0);

    // Reset in the middle of a normalisation.
    @(negedge clk);
    in_valid = 1'b1;
    mode     = 1'b0;
    in_int   = 8'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid.state_shift", dbg_state, 1);
    reset = 1'b1;
    #1;
    chk("mid.out_valid", out_valid, 0);
    chk("mid.out_float", out_float, 0);
    chk("mid.out_int", out_int, 0);
    chk("mid.out_ovf", out_ovf, 0);
    chk("mid.state", dbg_state, 0);
    @(negedge clk);
    reset = 1'b0;
    run_conv("post_rst_3", 1'b0, 8'd3, 13'h0, 8'h00, 13'h02C0, 1'b0, 7, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/int_float_conv_seq.md
Name: int_float_conv_seq

Overview:
- Parametrised, bidirectional converter between a signed two's-complement integer and the team's sign/exponent/fraction float format.
- Uses an iterative one-bit-per-cycle normaliser/denormaliser instead of a wide combinational priority shifter, trading latency for area.
- Sits between integer datapaths and float arithmetic, with valid/ready handshakes on both sides.
- Mode is selected per transaction.

Parameters:
- IW, 8: integer width (two's complement), >= 2
- EW, 4: exponent width (unsigned, unbiased); must satisfy 2^EW-1 >= IW
- MW, 8: fraction width; float value = (-1)^s * 0.f * 2^e, f normalised with explicit leading 1

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  input transaction present
- in_ready  out  1  high only in IDLE
- mode  in  1  0 = int->float, 1 = float->int; captured at accept
- in_int  in  IW  signed integer operand (mode 0)
- in_float  in  1+EW+MW  {s, e[EW-1:0], f[MW-1:0]} operand (mode 1)
- out_valid  out  1  result held stable until out_ready
- out_ready  in  1  consumer accepts
- out_int  out  IW  signed result (mode 1), else 0
- out_float  out  1+EW+MW  float result (mode 0), else 0
- out_ovf  out  1  float->int saturated (mode 1 only)

Behaviour:
- Reset (asynchronous, any state, mid-operation included):
  - state = IDLE
  - out_valid, out_int, out_float, out_ovf = 0
  - any in-flight transaction is discarded
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE: in_ready = 1. Accept when in_valid = 1. The accepting edge loads the working registers and moves to SHIFT.
- Mode 0 load:
  - sign = in_int[IW-1]
  - mag = |in_int|, held as IW-bit unsigned, so -2^(IW-1) is representable
  - exp = IW
- Mode 0 SHIFT, each edge:
  - if mag == 0 or mag[IW-1] == 1, go to DONE
  - otherwise mag <<= 1 and exp -= 1
- Mode 0 fraction: f = top MW bits of mag. Zero-pad on the right if MW > IW; truncate LSBs toward zero if MW < IW.
- Mode 0 zero input: result is all-zero, sign 0.
- Mode 1 load:
  - R = top IW bits of f (zero-padded if MW < IW)
  - cnt = IW - e when e <= IW, else 0
  - ovf_pre = (e > IW)
- Mode 1 SHIFT, each edge:
  - if cnt == 0, go to DONE
  - otherwise R >>= 1 and cnt -= 1
  - dropped bits truncate toward zero
- Mode 1 zero cases: e == 0 or f == 0 gives result 0 and ovf 0.
- Mode 1 overflow: ovf = ovf_pre, or (s == 0 and R > 2^(IW-1)-1), or (s == 1 and R > 2^(IW-1)).
  - On overflow, saturate to 2^(IW-1)-1 if s = 0, or to -2^(IW-1) if s = 1.
  - Otherwise out_int = s ? -R : R.
- Transition into DONE:
  - output registers load on this edge (negation and saturation are combinational into the register)
  - out_valid = 1 from this edge onward
- Latency, counted in edges from the accepting edge to out_valid high:
  - mode 0: lz + 1, where lz = leading zeros of mag; zero input takes 1
  - mode 1: (IW - e) + 1 when 0 < e <= IW; 1 otherwise
- DONE:
  - outputs held stable while out_ready = 0
  - on out_valid && out_ready: out_valid clears and state goes to IDLE
  - in_ready is high on the following cycle; no back-to-back accept
- The unused-mode output is 0.
- in_valid outside IDLE is ignored. Inputs are sampled only at the accepting edge.

Decomposition:
- Package int_float_pkg holds:
  - FW = 1+EW+MW
  - state encoding (IDLE, SHIFT, DONE)
  - mode constants MODE_I2F = 0, MODE_F2I = 1
  - saturation constant helpers
- One sub-module: int_float_shift_unit, which holds the working register, the exp/cnt counter and the direction-selectable 1-bit shift with its done detect. The top level keeps the FSM, handshake and output registers.

Test Plan:
- Mode 0, in_int = 25 -> out_float = 0_0101_11001000; out_valid 4 edges after accept.
- Mode 0, in_int = -128, then 127, then 0:
  - -128 -> 1_1000_10000000, latency 1
  - 127 -> 0_0111_11111110, latency 2
  - 0 -> all zero, latency 1
- Mode 1, in_float = 0_0101_11001000 -> out_int = 25, ovf 0, latency 4.
- Mode 1 overflow/saturation:
  - 1_1000_10000000 -> -128, ovf 0
  - 0_1000_10000000 -> 127, ovf 1
  - 0_1001_10000000 -> 127, ovf 1
  - 1_1010_11111111 -> -128, ovf 1
  - 0_0000_xxxxxxxx -> 0, ovf 0
- Backpressure: hold out_ready = 0 for 5 cycles -> outputs stable, in_ready = 0, a new in_valid is ignored; after out_ready, in_ready = 1 next cycle.
- Assert reset mid-SHIFT (mode 0, in_int = 1) -> out_valid = 0 and outputs 0 immediately, state IDLE; the next transaction with in_int = 3 converts to 0_0010_11000000.
